// File: rtl/bit_register.sv
// +--------------------------------------------------------------------------+
// | Module      : bit_register                                               |
// | Description : Load-enabled storage cell, replicated WIDTH times, async   |
// |               active-low reset to RESET_VALUE.                           |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
`default_nettype none

module bit_register #(
  parameter int unsigned           WIDTH       = 1,
  parameter logic [WIDTH-1:0]      RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] in,
  output logic [WIDTH-1:0] out
);

  logic [WIDTH-1:0] r_q;

  // One independent cell per bit; each bit sees only its own data and reset value.
  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_q[i] <= RESET_VALUE[i];
      end else if (load) begin
        r_q[i] <= in[i];
      end
    end
  end

  assign out = r_q;

endmodule

`default_nettype wire

// File: tb/tb_bit_register.sv
// +--------------------------------------------------------------------------+
// | Module      : tb_bit_register                                            |
// | Description : Self-checking bench for bit_register (1-bit and 16-bit).  |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_bit_register;

  localparam logic [15:0] RV16 = 16'h00A5;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        load1, load16;
  logic        in1;
  logic [15:0] in16;
  logic        out1;
  logic [15:0] out16;

  // Expected stored values
  logic        m1;
  logic [15:0] m16;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  bit_register u_bit (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (load1),
    .in    (in1),
    .out   (out1)
  );

  bit_register #(.WIDTH(16), .RESET_VALUE(RV16)) u_reg16 (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (load16),
    .in    (in16),
    .out   (out16)
  );

  // Advance to the next rising edge, applying the storage rule to the model
  // with the inputs presented before that edge; returns 1 time unit later.
  task automatic cycle();
    if (rst_n === 1'b1) begin
      if (load1)  m1  = in1;
      if (load16) m16 = in16;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic assert_reset();
    rst_n = 1'b0;
    m1    = 1'b0;
    m16   = RV16;
  endtask

  task automatic test_reset();
    @(negedge clk);
    #1;
    load1 = 1'b1; in1 = 1'b1; load16 = 1'b1; in16 = 16'hFFFF;
    assert_reset();
    #1;
    tests++; if (out1 !== m1) begin fails++; $display("FAIL reset_async out1: got %b want %b", out1, m1); end
    tests++; if (out16 !== m16) begin fails++; $display("FAIL reset_async out16: got %h want %h", out16, m16); end
    repeat (3) begin
      cycle();
      tests++; if (out1 !== 1'b0) begin fails++; $display("FAIL reset_held out1: got %b want 0", out1); end
      tests++; if (out16 !== RV16) begin fails++; $display("FAIL reset_held out16: got %h want %h", out16, RV16); end
    end
    load1 = 1'b0; load16 = 1'b0;
    rst_n = 1'b1;
    repeat (2) begin
      cycle();
      tests++; if (out1 !== 1'b0) begin fails++; $display("FAIL reset_release out1: got %b want 0", out1); end
      tests++; if (out16 !== RV16) begin fails++; $display("FAIL reset_release out16: got %h want %h", out16, RV16); end
    end
  endtask

  task automatic test_load_zero();
    in1 = 1'b0; load1 = 1'b1;
    cycle();
    tests++; if (out1 !== 1'b0) begin fails++; $display("FAIL load_zero: got %b want 0", out1); end
    in1 = 1'b1; load1 = 1'b0;
    repeat (3) begin
      cycle();
      tests++; if (out1 !== 1'b0) begin fails++; $display("FAIL load_zero_hold: got %b want 0", out1); end
    end
  endtask

  task automatic test_load_one();
    in1 = 1'b1; load1 = 1'b1;
    #3;
    tests++; if (out1 !== 1'b0) begin fails++; $display("FAIL load_one_early: got %b want 0", out1); end
    cycle();
    tests++; if (out1 !== 1'b1) begin fails++; $display("FAIL load_one: got %b want 1", out1); end
    in1 = 1'b0; load1 = 1'b0;
    repeat (3) begin
      cycle();
      tests++; if (out1 !== 1'b1) begin fails++; $display("FAIL load_one_hold: got %b want 1", out1); end
    end
  endtask

  task automatic test_hold_toggle();
    in16 = 16'h5A5A; load16 = 1'b1;
    cycle();
    load1 = 1'b0; load16 = 1'b0;
    repeat (5) begin
      in1 = ~in1; in16 = ~in16;
      #5;
      tests++; if (out1 !== m1) begin fails++; $display("FAIL hold_toggle_mid out1: got %b want %b", out1, m1); end
      in1 = ~in1; in16 = ~in16;
      cycle();
      tests++; if (out1 !== 1'b1) begin fails++; $display("FAIL hold_toggle out1: got %b want 1", out1); end
      tests++; if (out16 !== 16'h5A5A) begin fails++; $display("FAIL hold_toggle out16: got %h want 5a5a", out16); end
    end
  endtask

  task automatic test_async_reset();
    #2;
    in1 = 1'b1; load1 = 1'b1; in16 = 16'hFFFF; load16 = 1'b1;
    assert_reset();
    #1;
    tests++; if (out1 !== 1'b0) begin fails++; $display("FAIL async_reset out1: got %b want 0", out1); end
    tests++; if (out16 !== RV16) begin fails++; $display("FAIL async_reset out16: got %h want %h", out16, RV16); end
    #2;
    rst_n = 1'b1;
    #1;
    tests++; if (out1 !== 1'b0) begin fails++; $display("FAIL async_release_noclk out1: got %b want 0", out1); end
    cycle();
    tests++; if (out1 !== 1'b1) begin fails++; $display("FAIL async_release_load out1: got %b want 1", out1); end
    tests++; if (out16 !== 16'hFFFF) begin fails++; $display("FAIL async_release_load out16: got %h want ffff", out16); end
  endtask

  task automatic test_wide();
    load16 = 1'b0;
    assert_reset();
    #1;
    tests++; if (out16 !== 16'h00A5) begin fails++; $display("FAIL wide_reset: got %h want 00a5", out16); end
    rst_n = 1'b1;
    in16 = 16'hBEEF; load16 = 1'b1;
    cycle();
    tests++; if (out16 !== 16'hBEEF) begin fails++; $display("FAIL wide_load: got %h want beef", out16); end
    in16 = 16'h1234; load16 = 1'b0;
    repeat (3) begin
      cycle();
      tests++; if (out16 !== 16'hBEEF) begin fails++; $display("FAIL wide_hold: got %h want beef", out16); end
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 200; n++) begin
      load1  = 1'($urandom);
      in1    = 1'($urandom);
      load16 = 1'($urandom);
      in16   = 16'($urandom);
      if ($urandom_range(0, 15) == 0) begin
        assert_reset();
        #1;
        tests++; if (out16 !== m16) begin fails++; $display("FAIL rand_reset out16: got %h want %h", out16, m16); end
        rst_n = 1'b1;
      end
      #3;
      tests++; if (out1 !== m1 || out16 !== m16) begin
        fails++; $display("FAIL rand_mid n=%0d: got %b/%h want %b/%h", n, out1, out16, m1, m16);
      end
      cycle();
      tests++; if (out1 !== m1 || out16 !== m16) begin
        fails++; $display("FAIL rand_edge n=%0d: got %b/%h want %b/%h", n, out1, out16, m1, m16);
      end
    end
  endtask

  initial begin
    rst_n = 1'b1; load1 = 1'b0; load16 = 1'b0; in1 = 1'b0; in16 = '0;
    m1 = 1'b0; m16 = RV16;
    test_reset();
    test_load_zero();
    test_load_one();
    test_hold_toggle();
    test_async_reset();
    test_wide();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
